imu_spi_serf: RTL and testbench

SPI responder that models the quadcopter's 6-axis inertial sensor at the far end of the inertial SPI link. It decodes 16-bit command frames from the SPI monarch and accepts configuration writes. It returns rate and acceleration register bytes on reads and asserts INT when a new sample is ready. It serves as the sensor stand-in for full-system simulation and for FPGA loopback testing of the inertial interface.

---
 rtl/imu_spi_serf.sv | 213 +++++++++++++++++++++
 tb/tb_imu_spi_serf.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/imu_spi_serf.sv
// SPI responder standing in for the 6-axis inertial sensor: 16-bit command frames, a small
// config/sample register map, and a data-ready INT flag.
module imu_spi_serf (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic        new_sample,
    input  logic [15:0] ptch_rt,
    input  logic [15:0] roll_rt,
    input  logic [15:0] yaw_rt,
    input  logic [15:0] ax,
    input  logic [15:0] ay,
    output logic        int_en
);

    localparam logic [7:0] WHO_AM_I = 8'h6A;

    typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

    state_e      state_q;
    logic        ss_meta_q, ss_sync_q, ss_prev_q;
    logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic        mosi_meta_q, mosi_sync_q;
    logic [15:0] tx_q, rx_q;
    logic [4:0]  rise_cnt_q, fall_cnt_q;
    logic [6:0]  addr_q;
    logic [7:0]  int_ctrl_q, ctrl1_xl_q, ctrl2_g_q, ctrl3_q;
    logic [15:0] ptch_q, roll_q, yaw_q, ax_q, ay_q;
    logic [15:0] pend_ptch_q, pend_roll_q, pend_yaw_q, pend_ax_q, pend_ay_q;
    logic        pend_q, snap_q, int_q;

    logic        ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic        direct_snap, snap_apply, commit, int_clr;
    logic [15:0] rx_shift;
    logic [7:0]  rd_byte;

    assign ss_rise   = ss_sync_q & ~ss_prev_q;
    assign ss_fall   = ~ss_sync_q & ss_prev_q;
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign rx_shift  = {rx_q[14:0], mosi_sync_q};

    // A sample arriving mid-frame is parked until SS_n rises so one frame never mixes samples.
    assign direct_snap = new_sample & ss_sync_q;
    assign snap_apply  = direct_snap | (ss_rise & pend_q);

    // rx_q[15] is the R/W bit once all 16 rises have been shifted in.
    assign commit  = ss_rise && (state_q == StDone);
    assign int_clr = commit && ((rx_q[15] && addr_q == 7'h2B) ||
                                (!rx_q[15] && addr_q == 7'h0D && !rx_q[1]));

    assign MISO   = tx_q[15] & ~ss_sync_q;
    assign INT    = int_q;
    assign int_en = int_ctrl_q[1];

    always_comb begin
        rd_byte = 8'h00;
        case (addr_q)
            7'h0D:   rd_byte = int_ctrl_q;
            7'h0F:   rd_byte = WHO_AM_I;
            7'h10:   rd_byte = ctrl1_xl_q;
            7'h11:   rd_byte = ctrl2_g_q;
            7'h14:   rd_byte = ctrl3_q;
            7'h22:   rd_byte = ptch_q[7:0];
            7'h23:   rd_byte = ptch_q[15:8];
            7'h24:   rd_byte = roll_q[7:0];
            7'h25:   rd_byte = roll_q[15:8];
            7'h26:   rd_byte = yaw_q[7:0];
            7'h27:   rd_byte = yaw_q[15:8];
            7'h28:   rd_byte = ax_q[7:0];
            7'h29:   rd_byte = ax_q[15:8];
            7'h2A:   rd_byte = ay_q[7:0];
            7'h2B:   rd_byte = ay_q[15:8];
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b1;
            sclk_sync_q <= 1'b1;
            sclk_prev_q <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            addr_q      <= '0;
            int_ctrl_q  <= '0;
            ctrl1_xl_q  <= '0;
            ctrl2_g_q   <= '0;
            ctrl3_q     <= '0;
            ptch_q      <= '0;
            roll_q      <= '0;
            yaw_q       <= '0;
            ax_q        <= '0;
            ay_q        <= '0;
            pend_ptch_q <= '0;
            pend_roll_q <= '0;
            pend_yaw_q  <= '0;
            pend_ax_q   <= '0;
            pend_ay_q   <= '0;
            pend_q      <= 1'b0;
            snap_q      <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            ss_meta_q   <= SS_n;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            sclk_meta_q <= SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;

            snap_q <= snap_apply;
            if (direct_snap) begin
                ptch_q <= ptch_rt;
                roll_q <= roll_rt;
                yaw_q  <= yaw_rt;
                ax_q   <= ax;
                ay_q   <= ay;
            end else if (snap_apply) begin
                ptch_q <= pend_ptch_q;
                roll_q <= pend_roll_q;
                yaw_q  <= pend_yaw_q;
                ax_q   <= pend_ax_q;
                ay_q   <= pend_ay_q;
            end

            if (new_sample && !ss_sync_q) begin
                pend_q      <= 1'b1;
                pend_ptch_q <= ptch_rt;
                pend_roll_q <= roll_rt;
                pend_yaw_q  <= yaw_rt;
                pend_ax_q   <= ax;
                pend_ay_q   <= ay;
            end else if (ss_rise) begin
                pend_q <= 1'b0;
            end

            if (snap_q && int_ctrl_q[1]) begin
                int_q <= 1'b1;
            end else if (int_clr) begin
                int_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        state_q    <= StCmd;
                        tx_q       <= '0;
                        rise_cnt_q <= '0;
                        fall_cnt_q <= '0;
                    end
                end
                StCmd: begin
                    if (ss_rise) begin
                        state_q <= StIdle;
                    end else if (sclk_rise) begin
                        rx_q       <= rx_shift;
                        rise_cnt_q <= rise_cnt_q + 5'd1;
                        if (rise_cnt_q == 5'd7) begin
                            addr_q  <= rx_shift[6:0];
                            state_q <= StData;
                        end
                    end else if (sclk_fall) begin
                        fall_cnt_q <= fall_cnt_q + 5'd1;
                        if (fall_cnt_q != 5'd0) tx_q <= {tx_q[14:0], 1'b0};
                    end
                end
                StData: begin
                    if (ss_rise) begin
                        state_q <= StIdle;
                    end else if (sclk_rise) begin
                        rx_q       <= rx_shift;
                        rise_cnt_q <= rise_cnt_q + 5'd1;
                        if (rise_cnt_q == 5'd15) state_q <= StDone;
                    end else if (sclk_fall) begin
                        fall_cnt_q <= fall_cnt_q + 5'd1;
                        if (fall_cnt_q == 5'd8) tx_q <= {rd_byte, 8'h00};
                        else                    tx_q <= {tx_q[14:0], 1'b0};
                    end
                end
                StDone: begin
                    if (ss_rise) begin
                        state_q <= StIdle;
                        if (!rx_q[15]) begin
                            case (addr_q)
                                7'h0D:   int_ctrl_q <= rx_q[7:0];
                                7'h10:   ctrl1_xl_q <= rx_q[7:0];
                                7'h11:   ctrl2_g_q  <= rx_q[7:0];
                                7'h14:   ctrl3_q    <= rx_q[7:0];
                                default: ;
                            endcase
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imu_spi_serf.sv
// Directed bench for imu_spi_serf: drives SPI frames at clk/16 and checks read bytes, INT timing,
// abort, mid-frame snapshot and mid-frame reset behaviour.
module tb_imu_spi_serf;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n, SCLK, MOSI, MISO, INT, new_sample, int_en;
    logic [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
    logic [15:0] rd;
    int          n_checks = 0;
    int          n_pass = 0;

    logic [7:0] burst_exp [10] = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'h0F, 8'h0F,
                                   8'h01, 8'h80, 8'hFE, 8'hFF};

    imu_spi_serf u_dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .INT        (INT),
        .new_sample (new_sample),
        .ptch_rt    (ptch_rt),
        .roll_rt    (roll_rt),
        .yaw_rt     (yaw_rt),
        .ax         (ax),
        .ay         (ay),
        .int_en     (int_en)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Drives n_rises SCLK cycles of cmd with SS_n left low; MISO captured on each rise.
    task automatic spi_xfer(input logic [15:0] cmd, input int n_rises, input int pulse_at,
                            output logic [15:0] data);
        data = '0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n_rises; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            data = {data[14:0], MISO};
            if (i == pulse_at) begin
                new_sample = 1'b1;
                @(negedge clk);
                new_sample = 1'b0;
                repeat (7) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
        end
    endtask

    task automatic ss_release();
        SS_n = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [15:0] cmd, output logic [15:0] data);
        spi_xfer(cmd, 16, -1, data);
        ss_release();
    endtask

    task automatic pulse_sample();
        @(negedge clk);
        new_sample = 1'b1;
        @(negedge clk);
        new_sample = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; new_sample = 1'b0;
        ptch_rt = '0; roll_rt = '0; yaw_rt = '0; ax = '0; ay = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("reset MISO", MISO, 0);
        check_eq("reset INT", INT, 0);
        check_eq("reset int_en", int_en, 0);

        spi_frame(16'h8F00, rd);
        check_eq("whoami", rd[7:0], 8'h6A);
        check_eq("INT idle", INT, 0);

        // Enable INT, then a sample with SS_n high.
        spi_frame(16'h0D02, rd);
        check_eq("int_en set", int_en, 1);
        spi_frame(16'h8D00, rd);
        check_eq("INT1_CTRL rd", rd[7:0], 8'h02);
        @(negedge clk);
        ptch_rt = 16'h1234;
        new_sample = 1'b1;
        @(negedge clk);
        new_sample = 1'b0;
        check_eq("INT not yet", INT, 0);
        @(negedge clk);
        check_eq("INT +1clk", INT, 1);
        spi_frame(16'hA200, rd);
        check_eq("ptch L", rd[7:0], 8'h34);
        spi_frame(16'hA300, rd);
        check_eq("ptch H", rd[7:0], 8'h12);

        // Full burst; INT falls 3 clk after SS_n rise of the 0x2B read.
        roll_rt = 16'hBEEF; yaw_rt = 16'h0F0F; ax = 16'h8001; ay = 16'hFFFE;
        pulse_sample();
        for (int a = 0; a < 9; a++) begin
            spi_frame({8'hA2 + 8'(a), 8'h00}, rd);
            check_eq($sformatf("burst 0x%0h", 8'h22 + 8'(a)), rd[7:0], burst_exp[a]);
        end
        spi_xfer(16'hAB00, 16, -1, rd);
        check_eq("burst 0x2b", rd[7:0], burst_exp[9]);
        check_eq("INT before clr", INT, 1);
        SS_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("INT +2clk", INT, 1);
        @(negedge clk);
        check_eq("INT clr +3clk", INT, 0);
        repeat (16) @(negedge clk);

        // Mid-frame sample is held until SS_n rises.
        ay = 16'h0000;
        pulse_sample();
        check_eq("INT zero snap", INT, 1);
        spi_frame(16'hAB00, rd);
        check_eq("ay H zero", rd[7:0], 8'h00);
        check_eq("INT clr2", INT, 0);
        ay = 16'h5555;
        spi_xfer(16'hAA00, 16, 3, rd);
        check_eq("ay L old", rd[7:0], 8'h00);
        check_eq("INT held", INT, 0);
        SS_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("INT pend +3", INT, 0);
        @(negedge clk);
        check_eq("INT pend +4", INT, 1);
        repeat (16) @(negedge clk);
        spi_frame(16'hAA00, rd);
        check_eq("ay L new", rd[7:0], 8'h55);

        // Writing int_en=0 clears INT; read-only and unmapped behaviour.
        spi_frame(16'h0D00, rd);
        check_eq("INT off wr", INT, 0);
        check_eq("int_en off", int_en, 0);
        spi_frame(16'h0F55, rd);
        spi_frame(16'h8F00, rd);
        check_eq("whoami ro", rd[7:0], 8'h6A);
        spi_frame(16'h8000, rd);
        check_eq("unmapped", rd[7:0], 8'h00);

        // Aborted write then a full one.
        spi_xfer(16'h1162, 10, -1, rd);
        ss_release();
        spi_frame(16'h9100, rd);
        check_eq("abort no wr", rd[7:0], 8'h00);
        spi_frame(16'h1162, rd);
        spi_frame(16'h9100, rd);
        check_eq("ctrl2 wr", rd[7:0], 8'h62);
        spi_frame(16'h1014, rd);
        spi_frame(16'h9000, rd);
        check_eq("ctrl1 wr", rd[7:0], 8'h14);

        // Reset in the middle of a write frame.
        spi_frame(16'h0D02, rd);
        spi_xfer(16'h1400 | 16'h00A5, 5, -1, rd);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst MISO", MISO, 0);
        check_eq("rst int_en", int_en, 0);
        check_eq("rst INT", INT, 0);
        SS_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        spi_frame(16'h8F00, rd);
        check_eq("post rst whoami", rd[7:0], 8'h6A);
        spi_frame(16'h9100, rd);
        check_eq("post rst ctrl2", rd[7:0], 8'h00);
        spi_frame(16'hAA00, rd);
        check_eq("post rst ay", rd[7:0], 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
